// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous memory between two requesters. Each
// requester presents read/write commands on a valid/ready handshake. The
// arbiter steers the granted command straight onto the memory pins in the
// same cycle. Read data comes back one cycle later, tagged for the requester
// that issued the read.
//
// Arbitration is round-robin with a bounded burst hold. The current owner
// keeps the grant for at most HOLD consecutive accepted commands while the
// other requester waits. After that limit the grant passes to the other side.
// An idle cycle ends the burst. The next contention is then settled by
// last_grant.
//
// Parameters
//   ADDR  memory address width
//   WORD  memory data width
//   HOLD  maximum consecutive grants to one requester under contention (>=1)
//
// Ports
//   clk           rising-edge clock, shared with the memory
//   rst_n         asynchronous active-low reset
//   req_valid[i]  requester i presents a command
//   req_ready[i]  command of requester i accepted this cycle
//   req_wr[i]     1 = write, 0 = read
//   req_addr      slice i = [i*ADDR +: ADDR]
//   req_wdata     slice i = [i*WORD +: WORD]
//   rsp_valid[i]  read data for requester i valid this cycle
//   rsp_rdata     read data (meaningful only while a rsp_valid bit is set)
//   mem_addr      memory address
//   mem_data_in   memory write data
//   mem_wr        memory write enable
//   mem_data_out  memory read data, valid the cycle after the address is sampled
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR = 4,
    parameter int WORD = 4,
    parameter int HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_wr,
    input  logic [2*ADDR-1:0] req_addr,
    input  logic [2*WORD-1:0] req_wdata,
    output logic [1:0]        rsp_valid,
    output logic [WORD-1:0]   rsp_rdata,
    output logic [ADDR-1:0]   mem_addr,
    output logic [WORD-1:0]   mem_data_in,
    output logic              mem_wr,
    input  logic [WORD-1:0]   mem_data_out
);

    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Burst bookkeeping: who owns the current burst and how many commands it
    // has had accepted in a row. A zero count means no burst is in progress.
    logic [CW-1:0]   hold_cnt;
    logic            owner;
    logic            last_grant;

    // Copy of the last granted address and data. The memory pins hold these
    // values while nobody is granted.
    logic [ADDR-1:0] addr_q;
    logic [WORD-1:0] data_q;

    logic            grant_any;
    logic            grant_id;
    logic [ADDR-1:0] sel_addr;
    logic [WORD-1:0] sel_wdata;
    logic            sel_wr;

    // Grant decision. A lone requester always wins. Under contention there are
    // three cases:
    //   - an active burst below its limit stays with the owner;
    //   - a burst at its limit hands the grant over to the other requester;
    //   - with no burst in progress, the requester that was not granted last
    //     wins.
    // Nothing is granted while reset is asserted.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end
            2'b10: begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
            2'b11: begin
                grant_any = 1'b1;
                if (hold_cnt == '0) begin
                    grant_id = ~last_grant;
                end else if (hold_cnt < HOLD_MAX) begin
                    grant_id = owner;
                end else begin
                    grant_id = ~owner;
                end
            end
            default: begin
                grant_any = 1'b0;
                grant_id  = 1'b0;
            end
        endcase
        if (!rst_n) begin
            grant_any = 1'b0;
        end
    end

    // Pick the command fields of the granted requester.
    always_comb begin
        sel_addr  = grant_id ? req_addr[ADDR +: ADDR]  : req_addr[0 +: ADDR];
        sel_wdata = grant_id ? req_wdata[WORD +: WORD] : req_wdata[0 +: WORD];
        sel_wr    = grant_id ? req_wr[1]               : req_wr[0];
    end

    // Handshake and memory pins. The granted command goes straight through.
    // Without a grant, the pins show the registered copy and write is off.
    always_comb begin
        req_ready   = 2'b00;
        mem_wr      = 1'b0;
        mem_addr    = addr_q;
        mem_data_in = data_q;
        if (grant_any) begin
            req_ready[0] = ~grant_id;
            req_ready[1] = grant_id;
            mem_wr       = sel_wr;
            mem_addr     = sel_addr;
            mem_data_in  = sel_wdata;
        end
    end

    // The memory returns data one cycle after the read address is sampled.
    // The arbiter forwards it unchanged, and rsp_valid says whose read it is.
    assign rsp_rdata = mem_data_out;

    // Burst state, last-granted command copy and the read-response tag.
    // A repeat grant to the owner extends the burst. The count saturates,
    // which only matters when the owner streams alone. A grant to the other
    // requester starts a new burst of one. An idle cycle clears the count but
    // keeps the owner. On reset the response tag is cleared, so an in-flight
    // read is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_valid  <= 2'b00;
        end else if (grant_any) begin
            if (grant_id == owner) begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + CNT_ONE;
                end
            end else begin
                owner    <= grant_id;
                hold_cnt <= CNT_ONE;
            end
            last_grant   <= grant_id;
            addr_q       <= sel_addr;
            data_q       <= sel_wdata;
            rsp_valid[0] <= ~sel_wr & ~grant_id;
            rsp_valid[1] <= ~sel_wr & grant_id;
        end else begin
            hold_cnt  <= '0;
            rsp_valid <= 2'b00;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. Instance dut_a uses HOLD=4 and instance dut_b uses
// HOLD=1. Each instance drives its own behavioural single-port memory.
//
// Expected values for dut_a come from a reference model that works at the
// command level. The model tracks which requester should win each cycle from
// the arbitration rules, and a word array holds what memory should contain.
// Directed scenarios use constant expected grant sequences and data. A
// randomized run checks every cycle against the model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int HOLD_A = 4;

    logic       clk;
    logic       rst_n;

    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [1:0] rsp_valid;
    logic [3:0] rsp_rdata;
    logic [3:0] mem_addr;
    logic [3:0] mem_data_in;
    logic       mem_wr;
    logic [3:0] mem_data_out;

    logic [1:0] b_req_valid;
    logic [1:0] b_req_ready;
    logic [1:0] b_req_wr;
    logic [7:0] b_req_addr;
    logic [7:0] b_req_wdata;
    logic [1:0] b_rsp_valid;
    logic [3:0] b_rsp_rdata;
    logic [3:0] b_mem_addr;
    logic [3:0] b_mem_data_in;
    logic       b_mem_wr;
    logic [3:0] b_mem_data_out;

    logic [3:0] mem_a [16];
    logic [3:0] mem_b [16];

    int n_checks;
    int n_fail;

    // Reference model state for dut_a
    int         cur_g;
    int         m_owner;
    int         m_cnt;
    int         m_last;
    logic [3:0] m_addr;
    logic [3:0] m_data;
    logic [3:0] ref_mem [16];
    logic [1:0] exp_rsp_v;
    logic [3:0] exp_rsp_d;

    mem_arbiter #(.ADDR(4), .WORD(4), .HOLD(HOLD_A)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_wr       (mem_wr),
        .mem_data_out (mem_data_out)
    );

    mem_arbiter #(.ADDR(4), .WORD(4), .HOLD(1)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (b_req_valid),
        .req_ready    (b_req_ready),
        .req_wr       (b_req_wr),
        .req_addr     (b_req_addr),
        .req_wdata    (b_req_wdata),
        .rsp_valid    (b_rsp_valid),
        .rsp_rdata    (b_rsp_rdata),
        .mem_addr     (b_mem_addr),
        .mem_data_in  (b_mem_data_in),
        .mem_wr       (b_mem_wr),
        .mem_data_out (b_mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous single-port memories, one per arbiter.
    always @(posedge clk) begin
        if (mem_wr) mem_a[mem_addr] <= mem_data_in;
        mem_data_out <= mem_a[mem_addr];
    end

    always @(posedge clk) begin
        if (b_mem_wr) mem_b[b_mem_addr] <= b_mem_data_in;
        b_mem_data_out <= mem_b[b_mem_addr];
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, test did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model ----------------

    function automatic int pred_grant(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        if (v == 2'b11) begin
            if (m_cnt == 0)      return (m_last == 0) ? 1 : 0;
            if (m_cnt < HOLD_A)  return m_owner;
            return 1 - m_owner;
        end
        return -1;
    endfunction

    function automatic logic [1:0] exp_ready();
        if (cur_g < 0) return 2'b00;
        return (cur_g == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic exp_mem_wr();
        if (cur_g < 0) return 1'b0;
        return (cur_g == 0) ? req_wr[0] : req_wr[1];
    endfunction

    function automatic logic [3:0] exp_mem_addr();
        if (cur_g < 0) return m_addr;
        return (cur_g == 0) ? req_addr[3:0] : req_addr[7:4];
    endfunction

    function automatic logic [3:0] exp_mem_data();
        if (cur_g < 0) return m_data;
        return (cur_g == 0) ? req_wdata[3:0] : req_wdata[7:4];
    endfunction

    task automatic model_reset();
        m_owner   = 0;
        m_cnt     = 0;
        m_last    = 1;
        m_addr    = 4'h0;
        m_data    = 4'h0;
        exp_rsp_v = 2'b00;
        exp_rsp_d = 4'h0;
        cur_g     = -1;
    endtask

    // ---------------- stimulus helpers (no checking) ----------------

    task automatic drive(input logic [1:0] v, input logic [1:0] w,
                         input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        req_valid = v;
        req_wr    = w;
        req_addr  = a;
        req_wdata = d;
        #1;
        cur_g = pred_grant(v);
    endtask

    // Advance through the active edge and update the model with what that
    // edge should have done.
    task automatic tick();
        logic [3:0] a;
        logic [3:0] d;
        logic       w;
        @(posedge clk);
        if (cur_g >= 0) begin
            a = (cur_g == 0) ? req_addr[3:0]  : req_addr[7:4];
            d = (cur_g == 0) ? req_wdata[3:0] : req_wdata[7:4];
            w = (cur_g == 0) ? req_wr[0]      : req_wr[1];
            if (cur_g == m_owner) begin
                if (m_cnt < HOLD_A) m_cnt = m_cnt + 1;
            end else begin
                m_owner = cur_g;
                m_cnt   = 1;
            end
            m_last = cur_g;
            m_addr = a;
            m_data = d;
            if (w) begin
                exp_rsp_v  = 2'b00;
                ref_mem[a] = d;
            end else begin
                exp_rsp_v = (cur_g == 0) ? 2'b01 : 2'b10;
                exp_rsp_d = ref_mem[a];
            end
        end else begin
            m_cnt     = 0;
            exp_rsp_v = 2'b00;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        req_valid   = 2'b00;
        req_wr      = 2'b00;
        b_req_valid = 2'b00;
        b_req_wr    = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_wr    = 2'b11;
        req_addr  = 8'hFF;
        req_wdata = 8'hFF;
        #1;
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_ready: got %b expected 00", req_ready);
        end
        n_checks++;
        if (mem_wr !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mem_wr: got %b expected 0", mem_wr);
        end
        n_checks++;
        if (mem_addr !== 4'h0 || mem_data_in !== 4'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_mem_pins: got addr %h data %h expected 0 0", mem_addr, mem_data_in);
        end
        n_checks++;
        if (rsp_valid !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_rsp_valid: got %b expected 00", rsp_valid);
        end
        @(negedge clk);
        req_valid = 2'b00;
        req_wr    = 2'b00;
        rst_n     = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        logic [1:0] v;
        logic [1:0] w;
        logic [3:0] a;
        logic [3:0] d;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            v = (k < 4) ? 2'b01 : 2'b00;
            w = (k < 2) ? 2'b01 : 2'b00;
            a = (k == 0 || k == 2) ? 4'd2 : 4'd3;
            d = (k == 0) ? 4'd7 : 4'd5;
            drive(v, w, {4'h0, a}, {4'h0, d});
            n_checks++;
            if (req_ready !== v) begin
                n_fail++;
                $display("[TB] FAIL single_ready[%0d]: got %b expected %b", k, req_ready, v);
            end
            n_checks++;
            if (rsp_valid !== ((k == 3 || k == 4) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("[TB] FAIL single_rsp_valid[%0d]: got %b", k, rsp_valid);
            end
            if (k == 3 || k == 4) begin
                n_checks++;
                if (rsp_rdata !== ((k == 3) ? 4'd7 : 4'd5)) begin
                    n_fail++;
                    $display("[TB] FAIL single_rdata[%0d]: got %h expected %h", k, rsp_rdata, (k == 3) ? 4'd7 : 4'd5);
                end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        int seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            drive(2'b11, 2'b00, {4'd9, 4'd1}, 8'h00);
            n_checks++;
            if (req_ready !== ((seq[k] == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("[TB] FAIL contention_grant[%0d]: got %b expected requester %0d", k, req_ready, seq[k]);
            end
            if (k > 0) begin
                n_checks++;
                if (rsp_valid !== ((seq[k-1] == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("[TB] FAIL contention_rsp[%0d]: got %b expected requester %0d", k, rsp_valid, seq[k-1]);
                end
                n_checks++;
                if (rsp_rdata !== exp_rsp_d) begin
                    n_fail++;
                    $display("[TB] FAIL contention_rdata[%0d]: got %h expected %h", k, rsp_rdata, exp_rsp_d);
                end
            end
            tick();
        end
    endtask

    task automatic test_hazard();
        apply_reset();
        drive(2'b10, 2'b10, {4'd4, 4'd0}, {4'hA, 4'h0});
        n_checks++;
        if (req_ready !== 2'b10 || mem_wr !== 1'b1 || mem_addr !== 4'd4) begin
            n_fail++;
            $display("[TB] FAIL hazard_write: got ready %b wr %b addr %h expected 10 1 4", req_ready, mem_wr, mem_addr);
        end
        tick();
        drive(2'b10, 2'b00, {4'd4, 4'd0}, 8'h00);
        n_checks++;
        if (req_ready !== 2'b10 || mem_wr !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL hazard_read: got ready %b wr %b expected 10 0", req_ready, mem_wr);
        end
        tick();
        drive(2'b00, 2'b00, 8'h00, 8'h00);
        n_checks++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 4'hA) begin
            n_fail++;
            $display("[TB] FAIL hazard_rsp: got valid %b data %h expected 10 a", rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_idle_release();
        apply_reset();
        repeat (2) begin
            drive(2'b01, 2'b00, 8'h00, 8'h00);
            tick();
        end
        drive(2'b00, 2'b00, 8'h00, 8'h00);
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL idle_no_grant: got %b expected 00", req_ready);
        end
        tick();
        drive(2'b11, 2'b00, 8'h21, 8'h00);
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL idle_release_grant: got %b expected 10", req_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        drive(2'b01, 2'b00, 8'h06, 8'h00);
        tick();
        #2;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_wr    = 2'b11;
        req_addr  = 8'h5A;
        req_wdata = 8'h3C;
        #1;
        n_checks++;
        if (rsp_valid !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL midread_rsp_in_reset: got %b expected 00", rsp_valid);
        end
        n_checks++;
        if (mem_wr !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL midread_pins_in_reset: got wr %b ready %b expected 0 00", mem_wr, req_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        req_wr    = 2'b00;
        model_reset();
        drive(2'b11, 2'b00, 8'h91, 8'h00);
        n_checks++;
        if (rsp_valid !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL midread_rsp_after: got %b expected 00", rsp_valid);
        end
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL midread_first_grant: got %b expected 01", req_ready);
        end
        tick();
    endtask

    task automatic test_hold1();
        logic [3:0] exp_b [16];
        logic [3:0] a0;
        logic [3:0] a1;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) exp_b[i] = mem_b[i];
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            a0 = 4'(k);
            a1 = 4'(k + 8);
            d  = 8'($urandom);
            b_req_valid = 2'b11;
            b_req_wr    = 2'b11;
            b_req_addr  = {a1, a0};
            b_req_wdata = d;
            #1;
            n_checks++;
            if (b_req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("[TB] FAIL hold1_grant[%0d]: got %b expected requester %0d", k, b_req_ready, k % 2);
            end
            n_checks++;
            if (b_mem_wr !== 1'b1 || b_mem_addr !== ((k % 2 == 0) ? a0 : a1)) begin
                n_fail++;
                $display("[TB] FAIL hold1_pins[%0d]: got wr %b addr %h", k, b_mem_wr, b_mem_addr);
            end
            if (k % 2 == 0) exp_b[a0] = d[3:0];
            else            exp_b[a1] = d[7:4];
            @(posedge clk);
        end
        @(negedge clk);
        b_req_valid = 2'b00;
        b_req_wr    = 2'b00;
        #1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (mem_b[i] !== exp_b[i]) begin
                n_fail++;
                $display("[TB] FAIL hold1_mem[%0d]: got %h expected %h", i, mem_b[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 300; k++) begin
            drive(2'($urandom_range(0, 3)), 2'($urandom), 8'($urandom), 8'($urandom));
            n_checks++;
            if (req_ready !== exp_ready()) begin
                n_fail++;
                $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", k, req_ready, exp_ready());
            end
            n_checks++;
            if (mem_wr !== exp_mem_wr() || mem_addr !== exp_mem_addr() || mem_data_in !== exp_mem_data()) begin
                n_fail++;
                $display("[TB] FAIL rand_mem_pins[%0d]: got wr %b addr %h data %h expected %b %h %h",
                         k, mem_wr, mem_addr, mem_data_in, exp_mem_wr(), exp_mem_addr(), exp_mem_data());
            end
            n_checks++;
            if (rsp_valid !== exp_rsp_v) begin
                n_fail++;
                $display("[TB] FAIL rand_rsp_valid[%0d]: got %b expected %b", k, rsp_valid, exp_rsp_v);
            end
            if (exp_rsp_v != 2'b00) begin
                n_checks++;
                if (rsp_rdata !== exp_rsp_d) begin
                    n_fail++;
                    $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", k, rsp_rdata, exp_rsp_d);
                end
            end
            tick();
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        req_valid   = 2'b00;
        req_wr      = 2'b00;
        req_addr    = 8'h00;
        req_wdata   = 8'h00;
        b_req_valid = 2'b00;
        b_req_wr    = 2'b00;
        b_req_addr  = 8'h00;
        b_req_wdata = 8'h00;
        for (int i = 0; i < 16; i++) begin
            mem_a[i]   = 4'h0;
            mem_b[i]   = 4'h0;
            ref_mem[i] = 4'h0;
        end
        model_reset();

        test_reset();
        test_single();
        test_contention();
        test_hazard();
        test_idle_release();
        test_reset_mid_read();
        test_hold1();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares one single-port synchronous memory (`mem`, ports clk/addr/data_in/wr/data_out; ADDR/WORD parameters).
- Each requester issues read/write commands over a valid/ready handshake.
- The arbiter drives the memory command pins and returns read data one cycle later to the requester that issued the read.
- Arbitration is round-robin with a bounded burst hold, so a streaming requester cannot starve the other.

Parameters:
- ADDR, 4, memory address width in bits.
- WORD, 4, memory data width in bits.
- HOLD, 4, maximum consecutive accepted commands for one requester while the other is waiting (must be ≥1).

Ports:
- clk  in  1  rising-edge clock shared with mem.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  bit i: requester i presents a command.
- req_ready  out  2  bit i: command of requester i accepted this cycle.
- req_wr  in  2  bit i: 1 = write, 0 = read.
- req_addr  in  2*ADDR  slice i = [i*ADDR +: ADDR].
- req_wdata  in  2*WORD  slice i = [i*WORD +: WORD].
- rsp_valid  out  2  bit i: read data for requester i is valid this cycle.
- rsp_rdata  out  WORD  read data; meaningful only while a rsp_valid bit is set.
- mem_addr  out  ADDR  to mem addr.
- mem_data_in  out  WORD  to mem data_in.
- mem_wr  out  1  to mem wr.
- mem_data_out  in  WORD  from mem data_out; valid the cycle after a read address is sampled.

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, hold counter=0, owner=requester 0, last_grant=1 (so requester 0 wins the first contention). While reset is asserted: req_ready=0, mem_wr=0, mem_addr=0, mem_data_in=0.
- Grant is combinational from current req_valid plus registered state. At most one req_ready bit is high per cycle. req_ready[i] is high only if req_valid[i] is high. No grant when both valid bits are 0.
- Arbitration rules:
  - Only one requester valid: grant it.
  - Both valid, owner's hold count < HOLD: grant owner.
  - Both valid, owner's hold count = HOLD: grant the other requester.
  - Both valid with no current owner: grant the requester not equal to last_grant.
- Hold counter and owner:
  - On each accepted command from requester i: if i = owner, counter+1 (saturating at HOLD); otherwise owner=i and counter=1. Set last_grant=i.
  - Cycle with no acceptance: counter=0, owner retained.
- Memory drive: mem_addr, mem_data_in and mem_wr come combinationally from the granted slice. mem_wr = granted & req_wr. With no grant, mem_wr=0 and addr/data hold the last granted values (registered copy).
- Write latency: a write is complete at its handshake edge. No response.
- Read latency: a read accepted at edge N gives rsp_valid[i]=1 for exactly one cycle after edge N, with rsp_rdata = mem_data_out.
  - Back-to-back reads produce back-to-back responses in issue order.
  - There is no rsp backpressure; requesters must always accept responses.
- Write followed by a read of the same address on the next accepted cycle returns the new data.
- Requester i deasserting req_valid without a handshake is legal; no state change results.
- Reset during an outstanding read drops the response; rsp_valid stays 0 after release.
- HOLD=1 gives strict alternation under continuous contention.

Test Plan:
- Single requester: req0 writes addr 2 = 7, then addr 3 = 5, then reads 2 and 3 -> req_ready[0]=1 each cycle; rsp_valid[0] pulses one cycle after each read with rdata 7, then 5; rsp_valid[1] stays 0.
- Contention from reset: both requesters continuously read (req0 addr 1, req1 addr 9) with HOLD=4 -> grant sequence is 0,0,0,0,1,1,1,1,0,…; each rsp_valid bit follows its grant by one cycle.
- Write/read hazard: req1 writes addr 4 = 0xA, then immediately reads addr 4 -> rsp_rdata = 0xA one cycle after the read handshake.
- Idle release: req0 holds the grant for 2 commands, idles 1 cycle, then both request -> counter resets; req1 wins (last_grant=0).
- Reset mid-read: read accepted, rst_n pulsed low before the next edge -> rsp_valid stays 0; after release, req0 wins the first contention; mem_wr=0 while in reset.
- HOLD=1, both writing -> grants strictly alternate 0,1,0,1; memory contents match every accepted write.
